// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: iterative shift-add multiplier, one multiplier bit per clock.
// Valid/ready handshake on both operand input and product output.
// Optional feature macro: SIGNED_MULT_EN enables two's-complement multiply when op_signed=1.
module seq_shift_add_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               op_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [PW-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   acc_next;
  logic [PW-1:0]   addend;
  logic [CW-1:0]   count;
  logic [PW-1:0]   mcand_init;
  logic            accept;
  logic            last_step;

  assign accept    = in_valid && in_ready;
  assign last_step = (count == LAST);

`ifdef SIGNED_MULT_EN
  logic sgn;

  // Sign-extend the multiplicand for signed ops so the shifted partial products carry the sign
  always_comb begin
    mcand_init = {{WIDTH{1'b0}}, a};
    if (op_signed) begin
      mcand_init = {{WIDTH{a[WIDTH-1]}}, a};
    end
  end

  // The MSB of a two's-complement multiplier has negative weight, so its partial product is subtracted
  always_comb begin
    addend   = mplier[0] ? mcand : '0;
    acc_next = acc + addend;
    if (sgn && last_step) begin
      acc_next = acc - addend;
    end
  end

  // Remember the operation type for the whole run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn <= 1'b0;
    end else if (accept) begin
      sgn <= op_signed;
    end
  end
`else
  logic unused_op_signed;
  assign unused_op_signed = op_signed;

  // Unsigned-only build: zero-extend the multiplicand
  always_comb begin
    mcand_init = {{WIDTH{1'b0}}, a};
  end

  // Unsigned-only build: plain accumulate, no subtract path
  always_comb begin
    addend   = mplier[0] ? mcand : '0;
    acc_next = acc + addend;
  end
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs decoded from state
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: load operands on accept, then one shift-add step per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        mcand  <= mcand_init;
        mplier <= b;
        acc    <= '0;
        count  <= '0;
      end
    end else if (state == RUN) begin
      acc    <= acc_next;
      mcand  <= {mcand[PW-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      count  <= count + CW'(1);
      if (last_step) begin
        product <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb_seq_shift_add_mult: directed checks of the shift-add multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_shift_add_mult;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       op_signed;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;
  logic       busy;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        out_valid8;
  logic [15:0] product8;
  logic        busy8;

  int n_compared;
  int n_mismatched;

  seq_shift_add_mult #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_signed(op_signed), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .busy(busy)
  );

  seq_shift_add_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op_signed(1'b0), .out_valid(out_valid8),
    .out_ready(1'b1), .product(product8), .busy(busy8)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=4 transaction: accept, measure latency, optional back-pressure, hand-off
  task automatic applyStimulus(input string tag, input logic [3:0] av, input logic [3:0] bv,
                               input logic sv, input logic [7:0] exp, input int hold,
                               input logic early_ready, input logic run_noise);
    int lat;
    @(negedge clk);
    checkOutput({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    a = av; b = bv; op_signed = sv; in_valid = 1'b1; out_ready = early_ready;
    @(posedge clk); #1;
    if (run_noise) begin
      a = ~av; b = ~bv; in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        checkOutput({tag, " in_ready run"}, 32'(in_ready), 32'd0);
        checkOutput({tag, " busy run"}, 32'(busy), 32'd1);
      end
    end
    in_valid = 1'b0;
    checkOutput({tag, " latency"}, 32'(lat), 32'd4);
    checkOutput({tag, " product"}, 32'(product), 32'(exp));
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      checkOutput({tag, " held out_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, " held product"}, 32'(product), 32'(exp));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, " out_valid after handoff"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " in_ready after handoff"}, 32'(in_ready), 32'd1);
    checkOutput({tag, " product kept"}, 32'(product), 32'(exp));
    out_ready = 1'b0;
  endtask

  // One WIDTH=8 transaction with the consumer always ready
  task automatic applyStimulus8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                                input logic [15:0] exp);
    int lat;
    @(negedge clk);
    a8 = av; b8 = bv; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'd8);
    checkOutput({tag, " product"}, 32'(product8), 32'(exp));
    @(posedge clk); #1;
    checkOutput({tag, " in_ready8 after handoff"}, 32'(in_ready8), 32'd1);
  endtask

  // Directed test sequence
  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    n_compared = 0;
    n_mismatched = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; op_signed = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset product", 32'(product), 32'd0);
    rst_n = 1'b1;

    applyStimulus("15x15", 4'd15, 4'd15, 1'b0, 8'hE1, 0, 1'b0, 1'b0);
    applyStimulus("0x9", 4'd0, 4'd9, 1'b0, 8'h00, 0, 1'b0, 1'b1);
    applyStimulus("9x0", 4'd9, 4'd0, 1'b0, 8'h00, 0, 1'b0, 1'b1);
    applyStimulus("13x11 backpressure", 4'd13, 4'd11, 1'b0, 8'h8F, 10, 1'b0, 1'b0);
    applyStimulus("7x6 early ready", 4'd7, 4'd6, 1'b0, 8'h2A, 0, 1'b1, 1'b0);
`ifdef SIGNED_MULT_EN
    applyStimulus("s -8x-8", 4'h8, 4'h8, 1'b1, 8'h40, 0, 1'b0, 1'b0);
    applyStimulus("s -8x7", 4'h8, 4'h7, 1'b1, 8'hC8, 0, 1'b0, 1'b0);
    applyStimulus("s 7x-1", 4'h7, 4'hF, 1'b1, 8'hF9, 0, 1'b0, 1'b0);
    applyStimulus("u 8x8 in signed build", 4'h8, 4'h8, 1'b0, 8'h40, 0, 1'b0, 1'b0);
`else
    applyStimulus("u 8x8 op_signed", 4'h8, 4'h8, 1'b1, 8'h40, 0, 1'b0, 1'b0);
    applyStimulus("u 8x7 op_signed", 4'h8, 4'h7, 1'b1, 8'h38, 0, 1'b0, 1'b0);
`endif

    // Abort in the middle of a run
    @(negedge clk);
    a = 4'd15; b = 4'd15; op_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("3x5 after abort", 4'd3, 4'd5, 1'b0, 8'h0F, 0, 1'b0, 1'b0);

    applyStimulus8("w8 255x255", 8'd255, 8'd255, 16'hFE01);
    applyStimulus8("w8 0x200", 8'd0, 8'd200, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      applyStimulus8("w8 random", ra, rb, 16'(ra) * 16'(rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
